// File: rtl/inv_shift_rows_state_pkg.sv
// Shared AES definitions for the inverse ShiftRows stage: widths, FSM encoding
// and the byte-index permutation used to read the stored state.
package inv_shift_rows_state_pkg;

    localparam int BYTE_W    = 8;
    localparam int IDX_W     = 4;
    localparam int NUM_BYTES = 16;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Source byte for each output position of the inverse row shift.
    localparam idx_t INV_SHIFT_IDX [NUM_BYTES] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

    // Column-major indexing turns the row rotation into a multiply mod 16.
    function automatic idx_t inv_shift_idx(input idx_t k);
        return idx_t'(k * 4'd13);
    endfunction

    function automatic idx_t fwd_shift_idx(input idx_t k);
        return idx_t'(k * 4'd5);
    endfunction

endpackage

// File: rtl/inv_shift_rows_mem.sv
// 16x8 flop array holding one AES state: one write port, asynchronous read.
module inv_shift_rows_mem
    import inv_shift_rows_state_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  idx_t  waddr,
    input  byte_t wdata,
    input  idx_t  raddr,
    output byte_t rdata
);

    byte_t mem_q [NUM_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == IDX_W'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inv_shift_rows_state.sv
// Inverse ShiftRows on a byte stream: collects 16 bytes, then replays them in
// inverse-shifted order straight from the flop array.
module inv_shift_rows_state
    import inv_shift_rows_state_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] data_in,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    logic [1:0] state_q, state_d;
    idx_t       wr_cnt_q, wr_cnt_d;
    idx_t       rd_cnt_q, rd_cnt_d;
    byte_t      rd_data;
    logic       mem_we;
    logic       xfer;

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DRAIN);
    assign busy      = in_ready | out_valid;
    assign mem_we    = in_ready & in_valid;
    assign xfer      = out_valid & out_ready;
    assign done      = xfer & (rd_cnt_q == 4'd15);
    assign out       = out_valid ? rd_data : '0;

    inv_shift_rows_mem u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_cnt_q),
        .wdata (data_in),
        .raddr (inv_shift_idx(rd_cnt_q)),
        .rdata (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    wr_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_cnt_d = wr_cnt_q + 4'd1;
                    if (wr_cnt_q == 4'd15) begin
                        state_d  = ST_DRAIN;
                        rd_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // start is deliberately not looked at here, so it never queues.
                if (out_ready) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                    if (rd_cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_state.sv
// Randomized self-checking bench for inv_shift_rows_state against a row/column
// model of AES ShiftRows and its inverse.
module tb_inv_shift_rows_state;

    typedef logic [7:0] blk_t [16];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] data_in;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inv_shift_rows_state dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Byte k sits at row k%4, column k/4; inverse shift: o[r][c] = s[r][(c-r) mod 4].
    task automatic ref_inv(input blk_t s, output blk_t o);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
    endtask

    // Forward shift: f[r][c] = s[r][(c+r) mod 4].
    task automatic ref_fwd(input blk_t s, output blk_t f);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[r + 4*c] = s[r + 4*((c + r) % 4)];
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after a posedge with the DUT idle; returns 1ns after the
    // edge that accepts the 16th byte.
    task automatic load_block(input blk_t b, input int start_at, input int gap_at);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                step();
                step();
            end
            in_valid = 1'b1;
            data_in  = b[i];
            start    = (i == start_at);
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic drain_block(input bit start_last, output blk_t got, output int n,
                               output int done_cnt, output int done_pos);
        n = 0;
        done_cnt = 0;
        done_pos = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) got[i] = 8'h00;
        for (int cyc = 0; cyc < 64 && n < 16; cyc++) begin
            #1;
            if (done) begin
                done_cnt++;
                done_pos = n;
            end
            if (out_valid && out_ready) begin
                got[n] = out;
                if (n == 15 && start_last) start = 1'b1;
                n++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; data_in = 8'hA5; out_ready = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
        rst = 1'b0; start = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignores_in_valid: busy=%b expected 0", busy); end
        in_valid = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_counting;
        blk_t src, exp, got;
        int n, dc, dp;
        for (int i = 0; i < 16; i++) src[i] = 8'(i);
        ref_inv(src, exp);
        load_block(src, -1, -1);
        checks++; if (out_valid !== 1'b1 || out !== exp[0]) begin errors++;
            $display("FAIL first_out_latency: out_valid=%b out=%h expected 1/%h", out_valid, out, exp[0]); end
        drain_block(1'b0, got, n, dc, dp);
        checks++; if (n !== 16) begin errors++; $display("FAIL count_drain_len: got %0d expected 16", n); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++;
                $display("FAIL count_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (dc !== 1 || dp !== 15) begin errors++;
            $display("FAIL count_done: count=%0d pos=%0d expected 1/15", dc, dp); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 8'h00) begin errors++;
            $display("FAIL count_after_done: out_valid=%b busy=%b out=%h expected 0/0/00", out_valid, busy, out); end
        $display("test_counting: transferred %0d bytes, last=%h", n, got[15]);
    endtask

    task automatic test_fips;
        blk_t src, exp, got;
        int n, dc, dp;
        src = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,
                8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
        exp = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,
                8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
        load_block(src, -1, -1);
        drain_block(1'b0, got, n, dc, dp);
        for (int i = 0; i < 16; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++;
                $display("FAIL fips_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL fips_done: count=%0d expected 1", dc); end
        $display("test_fips: transferred %0d bytes", n);
    endtask

    task automatic test_stall;
        blk_t src, exp, got;
        int n, dc, stalls;
        for (int i = 0; i < 16; i++) src[i] = 8'(i);
        ref_inv(src, exp);
        load_block(src, -1, 4);
        n = 0; dc = 0; stalls = 0;
        for (int i = 0; i < 16; i++) got[i] = 8'h00;
        for (int cyc = 0; cyc < 64 && n < 16; cyc++) begin
            out_ready = !(n == 5 && stalls < 3);
            #1;
            if (done) dc++;
            if (!out_ready) begin
                stalls++;
                checks++; if (out_valid !== 1'b1 || out !== exp[5]) begin errors++;
                    $display("FAIL stall_hold%0d: out_valid=%b out=%h expected 1/%h", stalls, out_valid, out, exp[5]); end
            end else if (out_valid) begin
                got[n] = out;
                n++;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        checks++; if (n !== 16 || stalls !== 3) begin errors++;
            $display("FAIL stall_progress: bytes=%0d stalls=%0d expected 16/3", n, stalls); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL stall_done: count=%0d expected 1", dc); end
        $display("test_stall: %0d stall cycles, %0d bytes", stalls, n);
    endtask

    task automatic test_abort;
        blk_t src, exp, got;
        int n, dc, dp, early_done;
        early_done = 0;
        for (int i = 0; i < 16; i++) src[i] = 8'(i);
        ref_inv(src, exp);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            data_in  = 8'hF0 | 8'(i);
            #1; if (done) early_done++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        if (done) early_done++;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out !== 8'h00) begin errors++;
            $display("FAIL abort_reset: busy=%b in_ready=%b out_valid=%b out=%h expected 0/0/0/00",
                     busy, in_ready, out_valid, out); end
        rst = 1'b0;
        step();
        if (done) early_done++;
        checks++; if (early_done !== 0) begin errors++;
            $display("FAIL abort_no_done: done pulses=%0d expected 0", early_done); end
        load_block(src, -1, -1);
        drain_block(1'b0, got, n, dc, dp);
        for (int i = 0; i < 16; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++;
                $display("FAIL abort_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL abort_done: count=%0d expected 1", dc); end
        $display("test_abort: second block %0d bytes", n);
    endtask

    task automatic test_start_ignored;
        blk_t src, exp, got;
        int n, dc, dp, bad;
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom_range(0, 255));
        ref_inv(src, exp);
        load_block(src, 6, -1);
        drain_block(1'b1, got, n, dc, dp);
        bad = 0;
        for (int i = 0; i < 16; i++) if (got[i] !== exp[i]) bad++;
        checks++; if (bad !== 0 || n !== 16) begin errors++;
            $display("FAIL start_ignored_data: %0d wrong bytes of %0d", bad, n); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL start_ignored_done: count=%0d expected 1", dc); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL start_not_queued: busy cycles=%0d expected 0", bad); end
        $display("test_start_ignored: %0d bytes, idle afterwards", n);
    endtask

    task automatic test_random;
        blk_t src, fwd, got;
        int n, dc, dp, bad;
        for (int blk = 0; blk < 500; blk++) begin
            for (int i = 0; i < 16; i++) src[i] = 8'($urandom_range(0, 255));
            ref_fwd(src, fwd);
            load_block(fwd, -1, -1);
            drain_block(1'b0, got, n, dc, dp);
            bad = 0;
            for (int i = 0; i < 16; i++) if (got[i] !== src[i]) bad++;
            checks++; if (bad !== 0 || n !== 16 || dc !== 1) begin errors++;
                $display("FAIL random_block%0d: wrong=%0d bytes=%0d done=%0d expected 0/16/1 (byte0 %h vs %h)",
                         blk, bad, n, dc, got[0], src[0]); end
        end
        $display("test_random: 500 blocks round-tripped");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = 8'h00; out_ready = 1'b1;
        test_reset();
        test_counting();
        test_fips();
        test_stall();
        test_abort();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
